// File: rtl/router_wh_xbar.sv
// Wormhole crossbar: N_IN inputs to N_OUT outputs, per-output round-robin, head-to-tail packet lock.
// Latency: one cycle from input handshake to out_valid on a registered output stage.
// Backpressure: in_ready depends combinationally on out_ready. Optional macro ROUTER_LOCK_TIMEOUT_EN adds lock timeout.
module router_wh_xbar #(
   parameter int N_IN    = 4,
   parameter int N_OUT   = 3,
   parameter int W       = 32,
   parameter int DW      = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_IN-1:0]                in_valid,
   output logic [N_IN-1:0]                in_ready,
   input  logic [N_IN*W-1:0]              in_data,
   input  logic [N_IN*DW-1:0]             in_dest,
   input  logic [N_IN-1:0]                in_last,
   output logic [N_OUT-1:0]               out_valid,
   input  logic [N_OUT-1:0]               out_ready,
   output logic [N_OUT*W-1:0]             out_data,
   output logic [N_OUT-1:0]               out_last,
   output logic [N_OUT*$clog2(N_IN)-1:0]  out_src,
   output logic                           drop_err
`ifdef ROUTER_LOCK_TIMEOUT_EN
   ,
   output logic [N_OUT-1:0]               timeout_err
`endif
);

   localparam int SW = $clog2(N_IN);

   // per-output arbitration / lock state
   logic [N_OUT-1:0]          locked_q;
   logic [N_OUT-1:0][SW-1:0]  owner_q;
   logic [N_OUT-1:0][SW-1:0]  ptr_q;
   // per-input packet state: mid_q = packet in flight to some output, drop_q = discarding a bad packet
   logic [N_IN-1:0]           mid_q;
   logic [N_IN-1:0]           drop_q;
   // registered output stage
   logic [N_OUT-1:0]          out_valid_q;
   logic [N_OUT-1:0][W-1:0]   out_data_q;
   logic [N_OUT-1:0]          out_last_q;
   logic [N_OUT-1:0][SW-1:0]  out_src_q;
   logic                      drop_err_q;
   logic                      drop_err_d;

   logic [N_OUT-1:0]          load;
   logic [N_OUT-1:0]          xfer;
   logic [N_OUT-1:0][SW-1:0]  sel;
   logic [N_IN-1:0]           drop_hd;

`ifdef ROUTER_LOCK_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [N_OUT-1:0][CW-1:0]  idle_cnt_q;
   logic [N_OUT-1:0]          tmo_q;
   assign timeout_err = tmo_q;
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;
   assign drop_err  = drop_err_q;

   // Grant selection per output and the resulting in_ready; nothing is granted while in reset
   always_comb begin
      logic found;
      int   idx;
      found      = 1'b0;
      idx        = 0;
      in_ready   = '0;
      xfer       = '0;
      sel        = '0;
      drop_hd    = '0;
      drop_err_d = 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
         load[o] = !out_valid_q[o] | out_ready[o];
         if (locked_q[o]) begin
            // only the owner may move; its dest field is not looked at
            sel[o] = owner_q[o];
            if (rst_n) begin
               in_ready[owner_q[o]] = load[o];
               xfer[o]              = in_valid[owner_q[o]] & load[o];
            end
         end else begin
            // first eligible head scanning upward from ptr+1
            found = 1'b0;
            for (int k = 1; k <= N_IN; k++) begin
               idx = (int'(ptr_q[o]) + k) % N_IN;
               if (!found && in_valid[idx] && !mid_q[idx] && !drop_q[idx] &&
                   ({1'b0, in_dest[idx*DW +: DW]} == (DW+1)'(o))) begin
                  found  = 1'b1;
                  sel[o] = SW'(idx);
               end
            end
            if (found && rst_n) begin
               in_ready[sel[o]] = load[o];
               xfer[o]          = load[o];
            end
         end
      end
      // heads with an out-of-range destination and the rest of their packet are sunk
      for (int i = 0; i < N_IN; i++) begin
         if (rst_n) begin
            if (drop_q[i]) begin
               in_ready[i] = 1'b1;
            end else if (in_valid[i] && !mid_q[i] &&
                         ({1'b0, in_dest[i*DW +: DW]} >= (DW+1)'(N_OUT))) begin
               in_ready[i] = 1'b1;
               drop_hd[i]  = 1'b1;
               drop_err_d  = 1'b1;
            end
         end
      end
   end

   // Output registers, lock/pointer updates and per-input packet tracking
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         locked_q    <= '0;
         owner_q     <= '0;
         mid_q       <= '0;
         drop_q      <= '0;
         out_valid_q <= '0;
         out_data_q  <= '0;
         out_last_q  <= '0;
         out_src_q   <= '0;
         drop_err_q  <= 1'b0;
         for (int o = 0; o < N_OUT; o++) ptr_q[o] <= SW'(N_IN - 1);
`ifdef ROUTER_LOCK_TIMEOUT_EN
         idle_cnt_q  <= '0;
         tmo_q       <= '0;
`endif
      end else begin
         drop_err_q <= drop_err_d;
         for (int i = 0; i < N_IN; i++) begin
            if (in_valid[i] && in_ready[i]) begin
               if (drop_q[i]) begin
                  if (in_last[i]) drop_q[i] <= 1'b0;
               end else if (drop_hd[i] && !in_last[i]) begin
                  drop_q[i] <= 1'b1;
               end
            end
         end
`ifdef ROUTER_LOCK_TIMEOUT_EN
         tmo_q <= '0;
`endif
         for (int o = 0; o < N_OUT; o++) begin
            if (load[o]) begin
               out_valid_q[o] <= xfer[o];
               if (xfer[o]) begin
                  out_data_q[o] <= in_data[sel[o]*W +: W];
                  out_last_q[o] <= in_last[sel[o]];
                  out_src_q[o]  <= sel[o];
               end
            end
            if (xfer[o]) begin
               if (locked_q[o]) begin
                  if (in_last[sel[o]]) begin
                     locked_q[o]   <= 1'b0;
                     ptr_q[o]      <= sel[o];
                     mid_q[sel[o]] <= 1'b0;
                  end
               end else if (in_last[sel[o]]) begin
                  ptr_q[o] <= sel[o];
               end else begin
                  locked_q[o]   <= 1'b1;
                  owner_q[o]    <= sel[o];
                  mid_q[sel[o]] <= 1'b1;
               end
`ifdef ROUTER_LOCK_TIMEOUT_EN
               idle_cnt_q[o] <= '0;
            end else if (locked_q[o]) begin
               // owner went quiet: release the output after TIMEOUT idle cycles
               if (idle_cnt_q[o] == CW'(TIMEOUT - 1)) begin
                  locked_q[o]     <= 1'b0;
                  mid_q[owner_q[o]] <= 1'b0;
                  ptr_q[o]        <= owner_q[o];
                  tmo_q[o]        <= 1'b1;
                  idle_cnt_q[o]   <= '0;
               end else begin
                  idle_cnt_q[o] <= idle_cnt_q[o] + 1'b1;
               end
            end else begin
               idle_cnt_q[o] <= '0;
`endif
            end
         end
      end
   end

endmodule
